spfp_issue_ctrl: RTL

//  Master end of the SPFPFU_intf protocol; sits in the EXE stage between the pipeline and spfp_fu.
//  - Accepts one SPFP instruction per valid/ready handshake and registers its operands.
//  - Holds start and operands stable until the FU returns done.
//  - Captures the FU results and presents them to MEM/WB with a valid/ready handshake.
//  - Supports flush, and an optional watchdog that retires an FU that never completes.

---
 rtl/spfp_issue_ctrl_pkg.sv | 38 +++
 rtl/spfp_issue_ctrl_wdog.sv | 31 +++
 rtl/spfp_issue_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spfp_issue_ctrl_pkg.sv
// Shared types for the SPFP issue controller: FU operation/select encodings, issue FSM states, watchdog width.
// The watchdog itself is only built when SPFP_TIMEOUT_EN is defined.
package spfp_issue_ctrl_pkg;

  localparam int SPFP_TMO_SZ = 8;

  typedef enum logic [3:0] {
    F_ADD,
    F_SUB,
    F_MUL,
    F_DIV,
    F_SQRT,
    F_MIN,
    F_MAX,
    F_CVT,
    F_LW,
    F_SW
  } SPFP_OP_TYPE;

  typedef enum logic [1:0] {
    SEL_FS1,
    SEL_FS2,
    SEL_IMM,
    SEL_ZERO
  } SPFP_SEL_TYPE;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_BUSY,
    ISS_DONE
  } SPFP_ISS_STATE;

  // Load/store ops produce an address and can raise the misaligned flag.
  function automatic logic is_mem_op(input SPFP_OP_TYPE op);
    return (op == F_LW) || (op == F_SW);
  endfunction

endpackage

// File: rtl/spfp_issue_ctrl_wdog.sv
// Watchdog for a BUSY operation: counts BUSY cycles without done and flags expiry at TIMEOUT_CYC-1.
// Instantiated by spfp_issue_ctrl only when SPFP_TIMEOUT_EN is defined.
module spfp_wdog
  import spfp_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic clear,
  input  logic busy,
  input  logic done,
  output logic expired
);

  localparam logic [SPFP_TMO_SZ-1:0] LIMIT = SPFP_TMO_SZ'(TIMEOUT_CYC - 1);

  logic [SPFP_TMO_SZ-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset_in || clear) begin
      cnt <= '0;
    end else if (busy && !done) begin
      cnt <= cnt + SPFP_TMO_SZ'(1);
    end
  end

  // A done in the expiry cycle still wins: the real result is taken instead.
  assign expired = busy && !done && (cnt == LIMIT);

endmodule

// File: rtl/spfp_issue_ctrl.sv
// SPFP issue controller: master end of the FU start/done protocol in EXE, with a result buffer toward MEM/WB.
// Optional watchdog retirement of a hung FU is enabled by defining SPFP_TIMEOUT_EN.
module spfp_issue_ctrl
  import spfp_issue_ctrl_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int PC_SZ = 32
`ifdef SPFP_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             ex_valid_in,
  output logic             ex_rdy_out,
  input  logic [FLEN-1:0]  ex_Fs1_in,
  input  logic [FLEN-1:0]  ex_Fs2_in,
  input  logic [FLEN-1:0]  ex_imm_in,
  input  SPFP_SEL_TYPE     ex_selx_in,
  input  SPFP_SEL_TYPE     ex_sely_in,
  input  SPFP_OP_TYPE      ex_op_in,
  input  logic [PC_SZ-1:0] ex_pc_in,
  output logic             fu_start,
  output logic [FLEN-1:0]  fu_Fs1,
  output logic [FLEN-1:0]  fu_Fs2,
  output logic [FLEN-1:0]  fu_imm,
  output SPFP_SEL_TYPE     fu_selx,
  output SPFP_SEL_TYPE     fu_sely,
  output SPFP_OP_TYPE      fu_op,
  input  logic             fu_done,
  input  logic [FLEN-1:0]  fu_Fd,
  input  logic [PC_SZ-1:0] fu_ls_addr,
  input  logic [FLEN-1:0]  fu_st_data,
  input  logic             fu_mis,
  output logic             out_valid,
  input  logic             out_rdy,
  output logic [FLEN-1:0]  out_Fd,
  output logic [PC_SZ-1:0] out_ls_addr,
  output logic [FLEN-1:0]  out_st_data,
  output logic             out_mis,
  output logic             out_tmo,
  output logic [PC_SZ-1:0] out_pc,
  output SPFP_ISS_STATE    iss_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1 at the clock edge;
  // ex_rdy_out is combinational (1 in IDLE, out_rdy in DONE), out_valid is registered and held until taken.
  logic             accept;
  logic             retire;
  logic [PC_SZ-1:0] pc_q;

  always_comb begin
    ex_rdy_out = 1'b0;
    case (iss_state)
      ISS_IDLE: ex_rdy_out = 1'b1;
      ISS_DONE: ex_rdy_out = out_rdy;
      default:  ex_rdy_out = 1'b0;
    endcase
    accept = ex_valid_in & ex_rdy_out;
    retire = (iss_state == ISS_DONE) & out_rdy;
  end

`ifdef SPFP_TIMEOUT_EN
  logic tmo_hit;

  spfp_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .clear   (flush_in | accept),
    .busy    (iss_state == ISS_BUSY),
    .done    (fu_done),
    .expired (tmo_hit)
  );
`else
  assign out_tmo = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      iss_state   <= ISS_IDLE;
      fu_start    <= 1'b0;
      fu_Fs1      <= '0;
      fu_Fs2      <= '0;
      fu_imm      <= '0;
      fu_selx     <= SEL_FS1;
      fu_sely     <= SEL_FS1;
      fu_op       <= F_ADD;
      pc_q        <= '0;
      out_valid   <= 1'b0;
      out_Fd      <= '0;
      out_ls_addr <= '0;
      out_st_data <= '0;
      out_mis     <= 1'b0;
      out_pc      <= '0;
`ifdef SPFP_TIMEOUT_EN
      out_tmo     <= 1'b0;
`endif
    end else if (flush_in) begin
      // Flush beats any same-cycle accept, done or retire; operand regs are simply left stale.
      iss_state <= ISS_IDLE;
      fu_start  <= 1'b0;
      out_valid <= 1'b0;
`ifdef SPFP_TIMEOUT_EN
      out_tmo   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        fu_Fs1    <= ex_Fs1_in;
        fu_Fs2    <= ex_Fs2_in;
        fu_imm    <= ex_imm_in;
        fu_selx   <= ex_selx_in;
        fu_sely   <= ex_sely_in;
        fu_op     <= ex_op_in;
        pc_q      <= ex_pc_in;
        fu_start  <= 1'b1;
        iss_state <= ISS_BUSY;
      end

      case (iss_state)
        ISS_IDLE: ;
        ISS_BUSY: begin
          if (fu_done) begin
            out_Fd      <= fu_Fd;
            out_ls_addr <= fu_ls_addr;
            out_st_data <= fu_st_data;
            out_mis     <= fu_mis;
            out_pc      <= pc_q;
            out_valid   <= 1'b1;
            fu_start    <= 1'b0;
            iss_state   <= ISS_DONE;
          end
`ifdef SPFP_TIMEOUT_EN
          else if (tmo_hit) begin
            out_Fd      <= '0;
            out_ls_addr <= '0;
            out_st_data <= '0;
            out_mis     <= 1'b0;
            out_pc      <= pc_q;
            out_tmo     <= 1'b1;
            out_valid   <= 1'b1;
            fu_start    <= 1'b0;
            iss_state   <= ISS_DONE;
          end
`endif
        end
        ISS_DONE: begin
          if (retire) begin
            out_valid <= 1'b0;
`ifdef SPFP_TIMEOUT_EN
            out_tmo   <= 1'b0;
`endif
            if (!accept) begin
              iss_state <= ISS_IDLE;
            end
          end
        end
        default: iss_state <= ISS_IDLE;
      endcase
    end
  end

endmodule
